btn_frontend: RTL and testbench
===============================

# btn_frontend

Button front-end for the drift score device. It takes the four raw pushbuttons (start/stop, range, speed, reset), synchronises and debounces each one, and turns presses into the level signals that the control unit consumes: a latched run flag, timed range/speed display requests, and a reset level. It sits between the board pins and the control unit's `i_start_stop`, `i_range_disp`, `i_speed_disp` and `i_rst` inputs.

## Interface
- `DB_CYCLES`, default 50000: number of consecutive cycles a synchronised button must differ from its debounced state before that state changes; must be ≥2.
- `HOLD_CYCLES`, default 150000000: number of cycles a range/speed display request stays asserted; must be ≥1.
- `i_clk` input 1: system clock; all state is updated on the rising edge.
- `i_rst` input 1: reset, asynchronous and active-high; clears all state.
- `i_btn_start` input 1: raw start/stop button, active-high, asynchronous to `i_clk`.
- `i_btn_range` input 1: raw range-display button, active-high, asynchronous.
- `i_btn_speed` input 1: raw speed-display button, active-high, asynchronous.
- `i_btn_reset` input 1: raw user-reset button, active-high, asynchronous.
- `o_start_stop` output 1: run flag; toggles on each debounced start press; drives control unit `i_start_stop`.
- `o_range_disp` output 1: high while the range display window is active.
- `o_speed_disp` output 1: high while the speed display window is active.
- `o_rst` output 1: debounced user-reset level; drives control unit `i_rst`.

## Operation
- Each button has its own chain: 2-FF synchroniser, then a debounce counter and a debounced `stable` bit.
  - Counter behaviour: increments while the synchroniser output ≠ `stable`, and clears to 0 whenever they are equal.
  - Commit: when the synchroniser output ≠ `stable` and the counter = `DB_CYCLES`-1, `stable` flips and the counter clears.
  - Width: the counter is wide enough for `DB_CYCLES`-1 and never wraps.
- A commit of `stable` from 0 to 1 is a press. Releases (1 to 0) produce no event, except on the reset button.
- `o_rst` equals the debounced reset `stable` bit. While it is high:
  - `o_start_stop` is forced to 0.
  - The display FSM is forced to IDLE.
  - Press events from the other buttons are discarded. Their debouncers keep running.
- Start press: `o_start_stop` ← ~`o_start_stop`.
- The display FSM has three states: IDLE, RANGE and SPEED. The hold timer is a down-counter sized for `HOLD_CYCLES`-1.
  - IDLE + range press goes to RANGE and loads the timer with `HOLD_CYCLES`-1.
  - IDLE + speed press goes to SPEED and loads the timer.
  - Range and speed pressed on the same cycle: range wins.
  - In RANGE or SPEED, a range press goes to RANGE and a speed press goes to SPEED. Both reload the timer, including a re-press of the current state's button. Range wins on a simultaneous press.
  - In RANGE or SPEED with no press: if the timer = 0 go to IDLE, otherwise decrement.
- Output decode: `o_range_disp` = (state==RANGE), `o_speed_disp` = (state==SPEED). They are mutually exclusive.
- A start press on the same cycle as a range or speed press: both are applied independently.
- Reset-button commit on the same cycle as other presses: the reset wins and the other presses are discarded.

## Timing
- Asynchronous `i_rst` clears, immediately and without waiting for a clock:
  - Synchronisers, `stable` bits, debounce counters and the hold timer go to 0.
  - The FSM goes to IDLE.
  - All outputs go to 0.
- Release of `i_rst` takes effect at the first clock edge after deassertion.
- Press latency: raw button goes high before edge k and stays steady. The synchroniser output changes at edge k+1, and the commit plus output update happen at edge k+1+`DB_CYCLES`.
- Glitches: any raw pulse shorter than `DB_CYCLES` cycles (as seen after synchronisation) causes no commit.
- Display window length: the display output rises on the commit edge and falls exactly `HOLD_CYCLES` cycles later, unless it is reloaded by a new press.
- `o_rst` rises `DB_CYCLES`+1 edges after the raw reset button rises. It falls with the same latency after release.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
(All scenarios use `DB_CYCLES`=4, `HOLD_CYCLES`=10.)
- Reset/latency: assert `i_rst` mid-cycle, then all outputs go to 0 with no clock edge. Then hold start raw high from edge k: `o_start_stop` goes to 1 at edge k+5. Release and press again: it goes back to 0.
- Bounce rejection: start raw toggles high 3 cycles, low 1, high 2, low. `o_start_stop` must stay 0 throughout.
- Display window: a range press commits at edge n. `o_range_disp` is 1 on edges n..n+9 and 0 from edge n+10. `o_speed_disp` stays 0 throughout.
- Reload and switch: a range press at edge n, then a speed press at edge n+6. `o_range_disp` falls and `o_speed_disp` rises at edge n+6, and `o_speed_disp` falls at edge n+16.
- Simultaneous presses: range and speed commit on the same edge, giving RANGE. Start and range commit together, so `o_start_stop` toggles and `o_range_disp`=1.
- User reset: with `o_start_stop`=1 and SPEED active, hold the reset button. `o_rst`=1, `o_start_stop`=0, `o_speed_disp`=0 all take effect on the reset commit edge. Range presses while the reset button is held produce no display.

Source files
------------

// File: rtl/btn_frontend.sv
// Button front-end: synchronises and debounces four raw pushbuttons and turns
// presses into a latched run flag, timed range/speed display windows and a reset level.
module btn_frontend #(
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 150000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_start,
    input  logic i_btn_range,
    input  logic i_btn_speed,
    input  logic i_btn_reset,
    output logic o_start_stop,
    output logic o_range_disp,
    output logic o_speed_disp,
    output logic o_rst
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // Button index: 0 start, 1 range, 2 speed, 3 user reset.
    localparam int B_START = 0;
    localparam int B_RANGE = 1;
    localparam int B_SPEED = 2;
    localparam int B_RESET = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RANGE = 2'd1,
        ST_SPEED = 2'd2
    } disp_state_e;

    logic [3:0]     sync1_q, sync1_d;
    logic [3:0]     sync2_q, sync2_d;
    logic [3:0]     stable_q, stable_d;
    logic [DBW-1:0] cnt_q [4];
    logic [DBW-1:0] cnt_d [4];
    logic [3:0]     commit;
    logic [3:0]     press;
    logic           user_rst;
    logic           press_start, press_range, press_speed;

    logic           run_q, run_d;
    disp_state_e    state_q, state_d;
    logic [HW-1:0]  timer_q, timer_d;

    always_comb begin
        sync1_d = {i_btn_reset, i_btn_speed, i_btn_range, i_btn_start};
        sync2_d = sync1_q;
        for (int i = 0; i < 4; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            commit[i]   = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    commit[i]   = 1'b1;
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press = commit & ~stable_q;
        // The next reset level gates presses so a reset commit beats same-cycle presses.
        user_rst    = stable_d[B_RESET];
        press_start = press[B_START] & ~user_rst;
        press_range = press[B_RANGE] & ~user_rst;
        press_speed = press[B_SPEED] & ~user_rst;
    end

    always_comb begin
        run_d   = run_q;
        state_d = state_q;
        timer_d = timer_q;
        if (user_rst) begin
            run_d   = 1'b0;
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            if (press_start) run_d = ~run_q;
            if (press_range) begin
                state_d = ST_RANGE;
                timer_d = HOLD_LAST;
            end else if (press_speed) begin
                state_d = ST_SPEED;
                timer_d = HOLD_LAST;
            end else if (state_q != ST_IDLE) begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            run_q    <= 1'b0;
            state_q  <= ST_IDLE;
            timer_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            run_q    <= run_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    assign o_start_stop = run_q;
    assign o_range_disp = (state_q == ST_RANGE);
    assign o_speed_disp = (state_q == ST_SPEED);
    assign o_rst        = stable_q[B_RESET];

endmodule

// File: tb/tb_btn_frontend.sv
// Directed bench for btn_frontend with DB_CYCLES=4, HOLD_CYCLES=10: reset, press latency,
// bounce rejection, display windows, reload/switch, simultaneous presses and user reset.
module tb_btn_frontend;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_btn_start = 1'b0;
    logic i_btn_range = 1'b0;
    logic i_btn_speed = 1'b0;
    logic i_btn_reset = 1'b0;
    logic o_start_stop, o_range_disp, o_speed_disp, o_rst;

    int total = 0;
    int bad   = 0;

    btn_frontend #(.DB_CYCLES(4), .HOLD_CYCLES(10)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_btn_start  (i_btn_start),
        .i_btn_range  (i_btn_range),
        .i_btn_speed  (i_btn_speed),
        .i_btn_reset  (i_btn_reset),
        .o_start_stop (o_start_stop),
        .o_range_disp (o_range_disp),
        .o_speed_disp (o_speed_disp),
        .o_rst        (o_rst)
    );

    always #5 i_clk = ~i_clk;

    // Advance past the next rising edge and settle before sampling or driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s, input logic r,
                           input logic p, input logic u);
        chk({tag, ".start"}, o_start_stop, s);
        chk({tag, ".range"}, o_range_disp, r);
        chk({tag, ".speed"}, o_speed_disp, p);
        chk({tag, ".rst"},   o_rst,        u);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 i_rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick(2);
        chk_all("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Start press latency: high before edge k, commit at k+5.
        i_btn_start = 1'b1;
        tick(5);
        chk("start_lat_k4", o_start_stop, 1'b0);
        tick(1);
        chk("start_lat_k5", o_start_stop, 1'b1);
        i_btn_start = 1'b0;
        tick(8);
        chk("start_release", o_start_stop, 1'b1);
        i_btn_start = 1'b1;
        tick(5);
        chk("start2_k4", o_start_stop, 1'b1);
        tick(1);
        chk("start2_k5", o_start_stop, 1'b0);
        i_btn_start = 1'b0;
        tick(8);

        // Bounce: high 3, low 1, high 2, low.
        i_btn_start = 1'b1; tick(1); chk("bounce", o_start_stop, 1'b0);
        tick(1); chk("bounce", o_start_stop, 1'b0);
        tick(1); chk("bounce", o_start_stop, 1'b0);
        i_btn_start = 1'b0; tick(1); chk("bounce", o_start_stop, 1'b0);
        i_btn_start = 1'b1; tick(1); chk("bounce", o_start_stop, 1'b0);
        tick(1); chk("bounce", o_start_stop, 1'b0);
        i_btn_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bounce_tail", o_start_stop, 1'b0);
        end

        // Display window: range commits at edge n, high n..n+9.
        i_btn_range = 1'b1;
        tick(5);
        chk("win_pre", o_range_disp, 1'b0);
        tick(1);
        chk("win_n", o_range_disp, 1'b1);
        chk("win_n_spd", o_speed_disp, 1'b0);
        i_btn_range = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk("win_on", o_range_disp, 1'b1);
            chk("win_spd", o_speed_disp, 1'b0);
        end
        tick(1);
        chk("win_n10", o_range_disp, 1'b0);
        chk("win_n10_spd", o_speed_disp, 1'b0);
        tick(4);

        // Reload and switch: range at n, speed at n+6, speed falls at n+16.
        i_btn_range = 1'b1;
        tick(6);
        chk("sw_n_rng", o_range_disp, 1'b1);
        i_btn_range = 1'b0;
        i_btn_speed = 1'b1;
        tick(5);
        chk("sw_n5_rng", o_range_disp, 1'b1);
        chk("sw_n5_spd", o_speed_disp, 1'b0);
        tick(1);
        chk("sw_n6_rng", o_range_disp, 1'b0);
        chk("sw_n6_spd", o_speed_disp, 1'b1);
        i_btn_speed = 1'b0;
        tick(9);
        chk("sw_n15_spd", o_speed_disp, 1'b1);
        tick(1);
        chk("sw_n16_spd", o_speed_disp, 1'b0);
        chk("sw_n16_rng", o_range_disp, 1'b0);
        tick(4);

        // Simultaneous range+speed: range wins.
        i_btn_range = 1'b1;
        i_btn_speed = 1'b1;
        tick(6);
        chk("sim_rng", o_range_disp, 1'b1);
        chk("sim_spd", o_speed_disp, 1'b0);
        i_btn_range = 1'b0;
        i_btn_speed = 1'b0;
        tick(12);
        chk("sim_idle_rng", o_range_disp, 1'b0);
        chk("sim_idle_spd", o_speed_disp, 1'b0);

        // Start and range together: both apply.
        i_btn_start = 1'b1;
        i_btn_range = 1'b1;
        tick(6);
        chk("sr_start", o_start_stop, 1'b1);
        chk("sr_rng", o_range_disp, 1'b1);
        i_btn_start = 1'b0;
        i_btn_range = 1'b0;
        tick(12);
        chk("sr_idle", o_range_disp, 1'b0);

        // User reset while running with SPEED active.
        i_btn_speed = 1'b1;
        tick(6);
        chk_all("ur_setup", 1'b1, 1'b0, 1'b1, 1'b0);
        i_btn_speed = 1'b0;
        i_btn_reset = 1'b1;
        tick(5);
        chk_all("ur_pre", 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_all("ur_commit", 1'b0, 1'b0, 1'b0, 1'b1);
        i_btn_range = 1'b1;
        i_btn_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk_all("ur_held", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        i_btn_range = 1'b0;
        i_btn_start = 1'b0;
        tick(8);
        i_btn_reset = 1'b0;
        tick(5);
        chk("ur_rel_pre", o_rst, 1'b1);
        tick(1);
        chk_all("ur_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
